// File: rtl/xcorr_preamble.sv
// Sliding complex cross-correlator against a fixed +/-1 QPSK preamble.
// Emits max+min/2 magnitude estimate every clock for the peak detector.
module xcorr_preamble #(
    parameter int                 seq_len  = 32,
    parameter int                 wdth_in  = 12,
    parameter int                 wdth_crr = 24,
    parameter logic [seq_len-1:0] coef_i   = 32'hB38F_0E25,
    parameter logic [seq_len-1:0] coef_q   = 32'h5A3C_96E1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [wdth_in-1:0] in_i,
    input  logic signed [wdth_in-1:0] in_q,
    output logic [wdth_crr-1:0]       corr_out,
    output logic                      corr_val
);

    localparam int S  = wdth_in + 1 + $clog2(seq_len);
    localparam int CW = $clog2(seq_len + 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                     state, state_nx;
    logic [CW-1:0]              cnt;
    logic                       fill_done;
    logic signed [wdth_in-1:0]  tap_i [seq_len];
    logic signed [wdth_in-1:0]  tap_q [seq_len];
    logic signed [S-1:0]        re_sum, im_sum;
    logic signed [S-1:0]        re_r, im_r;
    logic [S-1:0]               abs_re, abs_im;
    logic [S-1:0]               mx, mn, mag;
    logic [wdth_crr-1:0]        mag_sat;
    logic                       v1, v2;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: if (cnt == CW'(seq_len - 1)) state_nx = RUN;
            RUN:  state_nx = RUN;
        endcase
    end

    always_comb begin
        fill_done = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (state == FILL) cnt <= cnt + 1'b1;
    end

    // Tap 0 holds the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < seq_len; j++) begin
                tap_i[j] <= '0;
                tap_q[j] <= '0;
            end
        end else begin
            tap_i[0] <= in_i;
            tap_q[0] <= in_q;
            for (int j = 1; j < seq_len; j++) begin
                tap_i[j] <= tap_i[j-1];
                tap_q[j] <= tap_q[j-1];
            end
        end
    end

    // Chip k lines up with tap seq_len-1-k; multiply by conj(chip).
    always_comb begin : sum_p
        logic signed [S-1:0] a, b;
        re_sum = '0;
        im_sum = '0;
        for (int k = 0; k < seq_len; k++) begin
            a = S'(tap_i[seq_len-1-k]);
            b = S'(tap_q[seq_len-1-k]);
            re_sum = re_sum + (coef_i[k] ? a : -a)
                            + (coef_q[k] ? b : -b);
            im_sum = im_sum + (coef_i[k] ? b : -b)
                            - (coef_q[k] ? a : -a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_r <= '0;
            im_r <= '0;
            v1   <= 1'b0;
        end else begin
            re_r <= re_sum;
            im_r <= im_sum;
            v1   <= fill_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_re <= '0;
            abs_im <= '0;
            v2     <= 1'b0;
        end else begin
            abs_re <= re_r[S-1] ? $unsigned(-re_r) : $unsigned(re_r);
            abs_im <= im_r[S-1] ? $unsigned(-im_r) : $unsigned(im_r);
            v2     <= v1;
        end
    end

    // Sums are bounded by 2^(S-1), so max + min/2 fits in S bits.
    always_comb begin
        mx  = (abs_re >= abs_im) ? abs_re : abs_im;
        mn  = (abs_re >= abs_im) ? abs_im : abs_re;
        mag = mx + (mn >> 1);
    end

    if (S <= wdth_crr) begin : g_ext
        assign mag_sat = wdth_crr'(mag);
    end else begin : g_sat
        assign mag_sat = (|mag[S-1:wdth_crr]) ? '1 : mag[wdth_crr-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_out <= '0;
            corr_val <= 1'b0;
        end else begin
            corr_out <= v2 ? mag_sat : '0;
            corr_val <= v2;
        end
    end

endmodule

// File: tb/tb_xcorr_preamble.sv
// Randomized and directed bench for xcorr_preamble against a queue-based
// complex correlation model; also covers a saturating and an all-ones variant.
module tb_xcorr_preamble;

    localparam int          SEQ  = 32;
    localparam logic [31:0] CI   = 32'hB38F_0E25;
    localparam logic [31:0] CQ   = 32'h5A3C_96E1;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] in_i = '0;
    logic signed [11:0] in_q = '0;
    logic [23:0]        out_d, out_o;
    logic [15:0]        out_s;
    logic               val_d, val_s, val_o;

    always #5 clk = ~clk;

    xcorr_preamble dut (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q),
        .corr_out(out_d), .corr_val(val_d)
    );

    xcorr_preamble #(.wdth_crr(16)) dut_sat (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q),
        .corr_out(out_s), .corr_val(val_s)
    );

    xcorr_preamble #(.coef_i(ONES), .coef_q(ONES)) dut_one (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q),
        .corr_out(out_o), .corr_val(val_o)
    );

    typedef struct {
        bit     v;
        longint m0;
        longint m1;
    } res_t;

    int     n_vec = 0;
    int     n_bad = 0;
    res_t   pipe[$];
    res_t   cur;
    int     hist_i[$];
    int     hist_q[$];
    int     edge_no = -1;
    bit     prev_val = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // hist[0] is newest; chip k pairs with hist[SEQ-1-k].
    function automatic longint mag_of(logic [31:0] ci, logic [31:0] cq);
        longint re = 0, im = 0, ar, ai, mx, mn;
        for (int k = 0; k < SEQ; k++) begin
            int a  = hist_i[SEQ-1-k];
            int b  = hist_q[SEQ-1-k];
            int cr = ci[k] ? 1 : -1;
            int cj = cq[k] ? 1 : -1;
            re += longint'(a * cr + b * cj);
            im += longint'(b * cr - a * cj);
        end
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return mx + mn / 2;
    endfunction

    function automatic res_t model_result();
        res_t r;
        r.v  = 1'b0;
        r.m0 = 0;
        r.m1 = 0;
        if (hist_i.size() >= SEQ) begin
            r.v  = 1'b1;
            r.m0 = mag_of(CI, CQ);
            r.m1 = mag_of(ONES, ONES);
        end
        return r;
    endfunction

    task automatic step();
        res_t   z;
        longint e0, es, e1;
        z.v  = 1'b0;
        z.m0 = 0;
        z.m1 = 0;
        @(posedge clk);
        if (rst) begin
            hist_i.delete();
            hist_q.delete();
            pipe.delete();
            repeat (3) pipe.push_back(z);
            cur     = z;
            edge_no = -1;
        end else begin
            hist_i.push_front(int'(in_i));
            hist_q.push_front(int'(in_q));
            if (hist_i.size() > SEQ) begin
                void'(hist_i.pop_back());
                void'(hist_q.pop_back());
            end
            pipe.push_back(model_result());
            cur = pipe.pop_front();
            edge_no++;
        end
        #1;
        e0 = cur.v ? cur.m0 : 0;
        es = (e0 > 65535) ? 65535 : e0;
        e1 = cur.v ? cur.m1 : 0;
        chk("corr_val", 64'(val_d), 64'(cur.v));
        chk("corr_out", 64'(out_d), e0);
        chk("sat_out", 64'(out_s), es);
        chk("ones_out", 64'(out_o), e1);
        chk("ones_val", 64'(val_o), 64'(cur.v));
        if (val_d && !prev_val)
            chk("val_rise_edge", 64'(edge_no), 64'(SEQ + 2));
        prev_val = val_d;
    endtask

    task automatic drive(input int i, input int q);
        in_i = 12'(i);
        in_q = 12'(q);
        step();
    endtask

    task automatic preamble(input int amp);
        for (int k = 0; k < SEQ; k++)
            drive(CI[k] ? amp : -amp, CQ[k] ? amp : -amp);
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) drive(0, 0);
        rst = 1'b0;

        repeat (40) drive(0, 0);
        drive(100, 0);
        repeat (3) drive(0, 0);
        chk("impulse_pk", 64'(out_d), 64'd150);
        repeat (31) drive(0, 0);
        chk("impulse_last", 64'(out_d), 64'd150);
        drive(0, 0);
        chk("impulse_end", 64'(out_d), 64'd0);

        preamble(1000);
        repeat (3) drive(0, 0);
        chk("match_pk", 64'(out_d), 64'd64000);
        for (int n = 0; n < 31; n++) begin
            drive(0, 0);
            chk("match_side", 64'(out_d < 24'd64000), 64'd1);
        end

        preamble(2047);
        repeat (3) drive(0, 0);
        chk("full_pk", 64'(out_d), 64'd131008);
        chk("sat_pk", 64'(out_s), 64'd65535);

        repeat (40) drive(-2048, -2048);
        chk("neg_ext", 64'(out_o), 64'd131072);

        repeat (150) drive(int'($urandom_range(0, 4095)) - 2048,
                           int'($urandom_range(0, 4095)) - 2048);

        for (int k = 0; k < 16; k++)
            drive(CI[k] ? 1500 : -1500, CQ[k] ? 1500 : -1500);
        rst = 1'b1;
        drive(1500, -1500);
        chk("rst_val", 64'(val_d), 64'd0);
        chk("rst_out", 64'(out_d), 64'd0);
        rst = 1'b0;
        for (int k = 16; k < SEQ; k++)
            drive(CI[k] ? 1500 : -1500, CQ[k] ? 1500 : -1500);
        preamble(1500);
        preamble(-900);
        repeat (3) drive(0, 0);

        repeat (100) drive(int'($urandom_range(0, 4095)) - 2048,
                           int'($urandom_range(0, 4095)) - 2048);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/xcorr_preamble.md
# xcorr_preamble

Sliding complex cross-correlator that sits directly upstream of the peak-search stage in the xcorr chain. It takes one complex baseband sample per clock, correlates the last `seq_len` samples against a fixed ±1 QPSK preamble, and emits an unsigned magnitude estimate every clock on `corr_out`. That output feeds the peak detector's `corr_in` without further conditioning.

## Interface
- `seq_len`, 32: preamble length in chips; power of two, at least 4.
- `wdth_in`, 12: signed width of each input I/Q component.
- `wdth_crr`, 24: output magnitude width; matches the downstream peak detector's `wdth_crr`.
- `coef_i`, 32'hB38F_0E25: I sign of each chip; bit k = chip k, 1 → +1, 0 → −1; width `seq_len`.
- `coef_q`, 32'h5A3C_96E1: Q sign of each chip, same encoding.

- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_i`, input, `wdth_in`: signed I sample; a new sample is captured every clock.
- `in_q`, input, `wdth_in`: signed Q sample.
- `corr_out`, output, `wdth_crr`: unsigned correlation magnitude.
- `corr_val`, output, 1: high once `corr_out` reflects a window filled entirely with post-reset samples.

## Operation
- **Delay line.** `seq_len` complex registers; tap 0 holds the newest sample. Each clock, captured samples shift one tap toward older.
- **Chip alignment.** Chip 0 is transmitted first. For the window x[n−seq_len+1 .. n], chip k is aligned with x[n−seq_len+1+k]. The peak occurs when the last chip sits in tap 0.
- **Per-chip term.** With a = I, b = Q, ci/cq = ±1, the sample is multiplied by conj(c):
  - re_k = a·ci + b·cq
  - im_k = b·ci − a·cq
  - These are sign flips and adds only; no multipliers.
- **Sums.** RE = Σ re_k and IM = Σ im_k, each signed with width S = `wdth_in` + 1 + clog2(`seq_len`). The sums are exact and never overflow.
- **Magnitude.** |RE| and |IM| are unsigned, S bits; the most negative value maps exactly. mag = max(|RE|,|IM|) + (min(|RE|,|IM|) >> 1), truncating the shift.
- **Output width.** mag is zero-extended to `wdth_crr` if S ≤ `wdth_crr`, otherwise saturated to all-ones.
- **Fill counter.** Counts captured samples from 0 to `seq_len` and then holds.
- **Flag pipeline.** A 3-stage valid-flag pipeline tracks the data pipeline.
- **Masking.** `corr_out` is forced to 0 while `corr_val` is 0.
- **No FSM beyond fill.** There are two states: FILL (counter < `seq_len`) and RUN. FILL → RUN happens when the `seq_len`-th sample is captured. RUN is left only by `rst`.

## Timing
- **Edge numbering.** Edge 0 is the first rising edge with `rst` low. A sample present before edge e is captured at edge e.
- **Pipeline.** Three register stages follow the capture:
  - edge e+1: RE/IM registered
  - edge e+2: |RE|/|IM| registered
  - edge e+3: `corr_out` registered
- **Latency.** 3 clocks from the capture edge to `corr_out` for the window ending at that sample. One result per clock with no bubbles.
- **`corr_val` rise.** The window first fills at capture edge `seq_len`−1. `corr_val` rises at edge `seq_len`+2, coincident with that window's result, and stays high until reset.
- **Reset values.** All of the following are 0: `corr_out`, `corr_val`, all delay taps, pipeline registers, fill counter.
- **Reset mid-operation.**
  - On the edge where `rst` is high: all state clears, and outputs read 0 from the next cycle.
  - Post-reset behaviour is identical to power-up, including the full `seq_len`+3 edge fill delay.
  - No pre-reset sample may contribute to any result flagged valid.
- **Input handshake.** There is no input handshake. Inputs are sampled unconditionally every clock, including during FILL.

## Test plan
- **Reset and fill:** hold `rst` 4 cycles, then drive constant in_i = in_q = 0 → `corr_out` = 0 throughout; `corr_val` first high at edge 34 (`seq_len` = 32); no X on any output.
- **Impulse:** in_i = 100 for one sample (captured at edge 40), otherwise 0 → `corr_out` = 150 (|RE| = |IM| = 100) at edges 43 through 74 inclusive, then 0.
- **Matched preamble:** drive in_i = ci_k·1000, in_q = cq_k·1000 for chips k = 0..31, with the last chip captured at edge t → `corr_out` = 64000 (RE = 64000, IM = 0) at edge t+3. Every other output within ±31 edges is below 64000.
- **Saturation:** set `wdth_crr` = 16 and drive the preamble at amplitude ±2047 → peak RE = 131008, so `corr_out` = 65535 at the peak. With default `wdth_crr` the same stimulus gives exactly 131008.
- **Negative extreme:** drive in_i = in_q = −2048 for 40 cycles with all-ones coefficients → RE = −131072 and IM = 0, so `corr_out` = 131072. Checks the abs of the most negative sum.
- **Mid-run reset:** during a running preamble stream, pulse `rst` for 1 cycle → `corr_out` = `corr_val` = 0 on the next cycle; `corr_val` returns exactly 35 edges after `rst` falls; the first valid output matches a golden model fed only post-reset samples.
